// File: rtl/ledtest_pio_poller.sv
// Periodically reads bit 0 of an Avalon-MM input PIO, debounces it and reports edges.
// One read per POLL_DIV idle cycles; a read with no readdatavalid in TIMEOUT_CYC cycles sets a sticky error.
module ledtest_pio_poller #(
   parameter int POLL_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int TIMEOUT_CYC  = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   input  logic        enable,
   input  logic        err_clr,
   output logic        sample,
   output logic        change_pulse,
   output logic [15:0] rise_count,
   output logic        busy,
   output logic        timeout_err
);

   localparam int TW  = $clog2(POLL_DIV);
   localparam int TOW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TMR_LAST  = TW'(POLL_DIV - 1);
   localparam logic [TOW-1:0] TOUT_LAST = TOW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]     DEB_LVL   = 8'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t         state_q;
   logic [TW-1:0]  timer_q;
   logic [TOW-1:0] to_q;
   logic           read_q;
   logic           busy_q;
   logic           sample_q;
   logic           pulse_q;
   logic           cand_q;
   logic [7:0]     stab_q;
   logic [15:0]    rise_count_q;
   logic           err_q;

   logic           bit_d;
   logic           cand_d;
   logic [7:0]     stab_d;
   logic           accept_d;
   logic           set_err_d;
   logic           unused_rd;

   assign unused_rd = ^avm_readdata[31:1];
   assign bit_d     = avm_readdata[0];

   // Debounce step for the bit currently on the bus; only committed on a valid response.
   always_comb begin
      cand_d = cand_q;
      stab_d = stab_q;
      if (bit_d != cand_q) begin
         cand_d = bit_d;
         stab_d = 8'd1;
      end else if (stab_q < DEB_LVL) begin
         stab_d = stab_q + 8'd1;
      end
      accept_d = (stab_d == DEB_LVL) && (cand_d != sample_q);
   end

   assign set_err_d = (state_q == RESP) && !avm_readdatavalid && (to_q == TOUT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         to_q         <= '0;
         read_q       <= 1'b0;
         busy_q       <= 1'b0;
         sample_q     <= 1'b0;
         pulse_q      <= 1'b0;
         cand_q       <= 1'b0;
         stab_q       <= 8'd0;
         rise_count_q <= 16'd0;
         err_q        <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!enable) begin
                  timer_q <= '0;
               end else if (timer_q == TMR_LAST) begin
                  timer_q <= '0;
                  state_q <= REQ;
                  read_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            REQ: begin
               if (!avm_waitrequest) begin
                  state_q <= RESP;
                  read_q  <= 1'b0;
                  to_q    <= '0;
               end
            end
            RESP: begin
               if (avm_readdatavalid) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cand_q  <= cand_d;
                  stab_q  <= stab_d;
                  if (accept_d) begin
                     sample_q <= cand_d;
                     pulse_q  <= 1'b1;
                     if (cand_d) begin
                        rise_count_q <= rise_count_q + 16'd1;
                     end
                  end
               end else if (to_q == TOUT_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  to_q <= to_q + TOW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               read_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
         // A timeout on the same edge as a clear keeps the flag set.
         if (set_err_d) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign avm_address  = 2'b00;
   assign avm_read     = read_q;
   assign busy         = busy_q;
   assign sample       = sample_q;
   assign change_pulse = pulse_q;
   assign rise_count   = rise_count_q;
   assign timeout_err  = err_q;

endmodule

// File: doc/ledtest_pio_poller.md
LEDTEST_PIO_POLLER -- requirements
Module: ledtest_pio_poller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- POLL_DIV, 50000, idle clk cycles between poll reads (min 2)
- DEBOUNCE_CNT, 4, consecutive equal samples to accept a level (min 1, max 255)
- TIMEOUT_CYC, 16, max RESP cycles awaiting readdatavalid (min 1)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high reset
- avm_address  out  2  Avalon-MM master address, constant 0 (data register of the input PIO)
- avm_read  out  1  Avalon-MM read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data; only bit 0 is used
- avm_readdatavalid  in  1  read data qualifier
- enable  in  1  polling enable
- err_clr  in  1  clears timeout_err
- sample  out  1  debounced input level
- change_pulse  out  1  one-cycle strobe when sample changes
- rise_count  out  16  count of debounced 0->1 transitions
- busy  out  1  high when state is not IDLE
- timeout_err  out  1  sticky read-timeout flag

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, REQ, RESP.
REQ-004 In IDLE with enable=1, a timer SHALL count 0..POLL_DIV-1.
- At POLL_DIV-1 the next state SHALL be REQ and the timer SHALL return to 0.
- With enable=0 the timer SHALL be held at 0.
REQ-005 In REQ, avm_read SHALL be 1.
- Leave REQ for RESP on the first edge with avm_waitrequest=0.
- While waitrequest=1, stay in REQ with no timeout.
REQ-006 avm_read SHALL be registered: 1 exactly in REQ cycles, 0 otherwise.
REQ-007 In RESP, a timeout counter SHALL count cycles from 0.
- If avm_readdatavalid=1, capture avm_readdata[0], apply the debounce update, and return to IDLE.
- If TIMEOUT_CYC cycles pass with no valid, set timeout_err=1, return to IDLE, and leave debounce state unchanged.
REQ-008 avm_readdatavalid SHALL be ignored outside RESP.
REQ-009 Debounce update on captured bit b, with internal cand (1 bit) and stab (8 bits):
- If b==cand and stab<DEBOUNCE_CNT, stab increments.
- If b!=cand, cand<=b and stab<=1.
REQ-010 When the updated stab reaches DEBOUNCE_CNT and cand!=sample:
- sample<=cand on that edge.
- change_pulse SHALL be 1 for exactly the following cycle.
- rise_count increments if the new sample=1.
REQ-011 rise_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-012 change_pulse SHALL be 0 in every other cycle.
REQ-013 Deasserting enable outside IDLE SHALL NOT abort the transaction; the FSM completes and then holds in IDLE.
REQ-014 timeout_err SHALL clear on err_clr=1; if a set and a clear occur on the same edge, the set SHALL win.
REQ-015 busy SHALL equal (state!=IDLE) and SHALL be registered.

Reset
REQ-016 While reset=1, and immediately on its assertion, all registers SHALL take these values:
- state=IDLE, timer=0, timeout counter=0
- avm_read=0, sample=0, cand=0, stab=0
- change_pulse=0, rise_count=0, busy=0, timeout_err=0
REQ-017 Reset asserted during REQ or RESP SHALL abandon the transaction.
- A readdatavalid arriving after reset release SHALL be ignored, per REQ-008.
REQ-018 avm_address SHALL be 0 during and after reset.

Verification (POLL_DIV=4, DEBOUNCE_CNT=3, TIMEOUT_CYC=16)
REQ-019 The bench SHALL cover these directed scenarios:
- Slave with waitrequest=0 and readdatavalid one cycle after acceptance, readdata=1, enable=1 -> first avm_read pulse begins on the 5th cycle after reset release; sample=1 with change_pulse after the 3rd poll; rise_count=1.
- Poll data 1,1,0,1,1,1 -> no change until the 6th poll; then sample=1 and rise_count=1.
- Slave holds waitrequest=1 for 10 cycles -> avm_read stays high for 11 cycles; no timeout_err.
- Slave never asserts readdatavalid -> timeout_err=1 after 16 RESP cycles; sample and rise_count unchanged; busy=0 the next cycle; err_clr pulse -> 0; err_clr on the set edge -> stays 1.
- Reset pulse while in RESP, followed by a stray readdatavalid=1 with data=1 -> all outputs 0, no debounce effect, IDLE.
- Force rise_count=0xFFFF via 65535 toggles (or a forced preload), then one more rising edge -> 0x0000, change_pulse=1.
